// File: rtl/umtrx_tx_sample_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : umtrx_tx_sample_bridge
//  Purpose  : Multi-channel TX sample handoff between VITA deframers and DUC
//             chains. Each channel has a small sample FIFO, prime/run/drain
//             sequencing, DAC-strobe-qualified pops, idle-sample fill on
//             underrun and a saturating underrun counter.
//  Revision : 1.0  initial release
// ============================================================================
module umtrx_tx_sample_bridge #(
  parameter int               NCHAN       = 2,
  parameter int               WIDTH       = 32,
  parameter int               DEPTH_LOG2  = 3,
  parameter int               PRIME_LVL   = 2,
  parameter logic [WIDTH-1:0] IDLE_SAMPLE = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NCHAN-1:0]                clear,
  input  logic [NCHAN*WIDTH-1:0]          in_data,
  input  logic [NCHAN-1:0]                in_valid,
  output logic [NCHAN-1:0]                in_ready,
  input  logic [NCHAN-1:0]                in_run,
  input  logic                            dac_stb,
  input  logic [NCHAN-1:0]                duc_strobe,
  output logic [NCHAN*WIDTH-1:0]          out_sample,
  output logic [NCHAN-1:0]                out_run,
  output logic [NCHAN-1:0]                underrun,
  output logic [NCHAN*16-1:0]             underrun_cnt,
  output logic [NCHAN*(DEPTH_LOG2+1)-1:0] fill
);

  localparam int              DEPTH      = 2**DEPTH_LOG2;
  localparam int              FW         = DEPTH_LOG2 + 1;
  localparam logic [FW-1:0]   FULL_LVL   = FW'(DEPTH);
  localparam logic [FW-1:0]   PRIME_FILL = FW'(PRIME_LVL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  genvar k;
  generate
    for (k = 0; k < NCHAN; k++) begin : g_chan
      logic [WIDTH-1:0]      mem [DEPTH];
      logic [DEPTH_LOG2-1:0] wr_ptr;
      logic [DEPTH_LOG2-1:0] rd_ptr;
      logic [FW-1:0]         cnt_fill;
      state_t                state;
      state_t                state_nxt;
      logic                  running;
      logic                  empty;
      logic                  push;
      logic                  pop_req;
      logic                  pop;
      logic                  starve;
      logic [WIDTH-1:0]      sample_q;
      logic                  underrun_q;
      logic [15:0]           ucnt_q;

      // Ready is withheld during reset and whenever the FIFO is full; a pop
      // in the same cycle does not open a slot until the next cycle.
      assign empty        = (cnt_fill == '0);
      assign in_ready[k]  = ~rst & (cnt_fill < FULL_LVL);
      assign push         = in_valid[k] & in_ready[k] & ~clear[k];
      assign pop_req      = duc_strobe[k] & dac_stb & running;
      assign pop          = pop_req & ~empty & ~clear[k];
      // Running dry mid-burst is an underrun; running dry while draining is
      // simply the end of the burst.
      assign starve       = pop_req & (state == ST_RUN) & empty;

      // Sample storage; no reset needed since occupancy gates every read.
      always_ff @(posedge clk) begin
        if (push) begin
          mem[wr_ptr] <= in_data[k*WIDTH +: WIDTH];
        end
      end

      // Pointers and occupancy; pointers wrap naturally at the FIFO depth.
      always_ff @(posedge clk) begin
        if (rst || clear[k]) begin
          wr_ptr   <= '0;
          rd_ptr   <= '0;
          cnt_fill <= '0;
        end else begin
          if (push) wr_ptr <= wr_ptr + 1'b1;
          if (pop)  rd_ptr <= rd_ptr + 1'b1;
          case ({push, pop})
            2'b10:   cnt_fill <= cnt_fill + FW'(1);
            2'b01:   cnt_fill <= cnt_fill - FW'(1);
            default: cnt_fill <= cnt_fill;
          endcase
        end
      end

      // Burst sequencing state register.
      always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
      end

      // Next-state and run decode; clear forces the channel back to idle.
      always_comb begin
        state_nxt = state;
        running   = 1'b0;
        case (state)
          ST_IDLE: begin
            if (in_run[k]) state_nxt = ST_PRIME;
          end
          ST_PRIME: begin
            if (cnt_fill >= PRIME_FILL) state_nxt = ST_RUN;
            else if (!in_run[k])        state_nxt = (empty && !push) ? ST_IDLE : ST_DRAIN;
          end
          ST_RUN: begin
            running = 1'b1;
            if (!in_run[k]) state_nxt = ST_DRAIN;
          end
          ST_DRAIN: begin
            running = 1'b1;
            if (in_run[k])           state_nxt = ST_RUN;
            else if (empty && !push) state_nxt = ST_IDLE;
          end
          default: state_nxt = ST_IDLE;
        endcase
        if (clear[k]) state_nxt = ST_IDLE;
      end

      // Output sample, underrun pulse and saturating underrun count.
      always_ff @(posedge clk) begin
        if (rst) begin
          sample_q   <= IDLE_SAMPLE;
          underrun_q <= 1'b0;
          ucnt_q     <= '0;
        end else if (clear[k]) begin
          sample_q   <= IDLE_SAMPLE;
          underrun_q <= 1'b0;
        end else begin
          underrun_q <= starve;
          if (starve && (ucnt_q != 16'hFFFF)) ucnt_q <= ucnt_q + 16'd1;
          if (pop_req)       sample_q <= empty ? IDLE_SAMPLE : mem[rd_ptr];
          else if (!running) sample_q <= IDLE_SAMPLE;
        end
      end

      assign out_sample[k*WIDTH +: WIDTH] = sample_q;
      assign out_run[k]                   = running;
      assign underrun[k]                  = underrun_q;
      assign underrun_cnt[k*16 +: 16]     = ucnt_q;
      assign fill[k*FW +: FW]             = cnt_fill;
    end
  endgenerate

endmodule
`default_nettype wire
